// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: combinational read port for EX, edge-committed writes,
// mcycle/minstret counters, trap entry/return state and registered interrupt-pending flag.
module csr_regfile #(
  parameter logic [63:0] HART_ID  = 64'd0,
  parameter logic [63:0] MISA_VAL = 64'h8000_0000_0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_data_i,
  output logic [63:0] csr_data_o,
  input  logic        instr_retire_i,
  input  logic        trap_i,
  input  logic [63:0] trap_cause_i,
  input  logic [63:0] trap_epc_i,
  input  logic [63:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  output logic [63:0] trap_pc_o,
  output logic [63:0] mret_pc_o,
  output logic        irq_pending_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [63:0] IRQ_MASK = 64'h0000_0000_0000_0888;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [63:0] mie_q, mie_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mtval_q, mtval_d;
  logic        msip_q, msip_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic        irq_q, irq_d;

  logic [63:0] mstatus_rd;
  logic [63:0] mip_rd;
  logic [63:0] tvec_base;

  assign mstatus_rd = {51'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
  assign mip_rd     = {52'd0, ext_irq_i, 3'd0, timer_irq_i, 3'd0, msip_q, 3'd0};
  assign tvec_base  = {mtvec_q[63:2], 2'b00};

  // Vectored offset applies only to interrupts; exceptions always land on the base.
  assign trap_pc_o     = (mtvec_q[0] && trap_cause_i[63])
                         ? tvec_base + {56'd0, trap_cause_i[5:0], 2'b00}
                         : tvec_base;
  assign mret_pc_o     = {mepc_q[63:2], 2'b00};
  assign irq_pending_o = irq_q;

  always_comb begin
    csr_data_o = 64'd0;
    case (csr_addr_i)
      ADDR_MSTATUS:  csr_data_o = mstatus_rd;
      ADDR_MISA:     csr_data_o = MISA_VAL;
      ADDR_MIE:      csr_data_o = mie_q;
      ADDR_MTVEC:    csr_data_o = mtvec_q;
      ADDR_MSCRATCH: csr_data_o = mscratch_q;
      ADDR_MEPC:     csr_data_o = mepc_q;
      ADDR_MCAUSE:   csr_data_o = mcause_q;
      ADDR_MTVAL:    csr_data_o = mtval_q;
      ADDR_MIP:      csr_data_o = mip_rd;
      ADDR_MCYCLE:   csr_data_o = mcycle_q;
      ADDR_MINSTRET: csr_data_o = minstret_q;
      ADDR_MHARTID:  csr_data_o = HART_ID;
      default:       csr_data_o = 64'd0;
    endcase
  end

  // Trap beats mret beats software write for the trap-owned registers.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (trap_i) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mepc_d         = {trap_epc_i[63:2], 2'b00};
      mcause_d       = trap_cause_i;
      mtval_d        = trap_tval_i;
    end else begin
      if (mret_i) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end else if (csr_we_i && csr_addr_i == ADDR_MSTATUS) begin
        mstatus_mie_d  = csr_data_i[3];
        mstatus_mpie_d = csr_data_i[7];
      end
      if (csr_we_i && csr_addr_i == ADDR_MEPC)   mepc_d   = {csr_data_i[63:2], 2'b00};
      if (csr_we_i && csr_addr_i == ADDR_MCAUSE) mcause_d = csr_data_i;
      if (csr_we_i && csr_addr_i == ADDR_MTVAL)  mtval_d  = csr_data_i;
    end
  end

  always_comb begin
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    msip_d     = msip_q;
    if (csr_we_i && csr_addr_i == ADDR_MIE)      mie_d      = csr_data_i & IRQ_MASK;
    if (csr_we_i && csr_addr_i == ADDR_MTVEC)    mtvec_d    = {csr_data_i[63:2], 1'b0, csr_data_i[0]};
    if (csr_we_i && csr_addr_i == ADDR_MSCRATCH) mscratch_d = csr_data_i;
    if (csr_we_i && csr_addr_i == ADDR_MIP)      msip_d     = csr_data_i[3];
    // A software write to a counter replaces that cycle's increment.
    mcycle_d   = (csr_we_i && csr_addr_i == ADDR_MCYCLE) ? csr_data_i : mcycle_q + 64'd1;
    minstret_d = (csr_we_i && csr_addr_i == ADDR_MINSTRET)
                 ? csr_data_i : minstret_q + {63'd0, instr_retire_i};
    irq_d      = mstatus_mie_q & (|(mie_q & mip_rd & IRQ_MASK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 64'd0;
      mtvec_q        <= 64'd0;
      mscratch_q     <= 64'd0;
      mepc_q         <= 64'd0;
      mcause_q       <= 64'd0;
      mtval_q        <= 64'd0;
      msip_q         <= 1'b0;
      mcycle_q       <= 64'd0;
      minstret_q     <= 64'd0;
      irq_q          <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      msip_q         <= msip_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      irq_q          <= irq_d;
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios followed by a randomized phase,
// all compared against a table-driven architectural model of the CSR file.
module tb_csr_regfile;

  localparam logic [63:0] MISA = 64'h8000_0000_0000_0100;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        csrWe = 1'b0;
  logic [11:0] csrAddr = 12'h0;
  logic [63:0] csrWdata = 64'd0;
  logic [63:0] csrRdata;
  logic        retire = 1'b0;
  logic        trap = 1'b0;
  logic [63:0] trapCause = 64'd0;
  logic [63:0] trapEpc = 64'd0;
  logic [63:0] trapTval = 64'd0;
  logic        mret = 1'b0;
  logic        timerIrq = 1'b0;
  logic        extIrq = 1'b0;
  logic [63:0] trapPc;
  logic [63:0] mretPc;
  logic        irqPend;

  int nChecks = 0;
  int nFails  = 0;

  // Architectural model: one entry per writable CSR holding its readable value.
  logic [63:0] st [int];
  logic        expIrq;

  csr_regfile #(.HART_ID(64'd0), .MISA_VAL(MISA)) dut (
    .clk(clk), .rst_n(rstN),
    .csr_we_i(csrWe), .csr_addr_i(csrAddr), .csr_data_i(csrWdata), .csr_data_o(csrRdata),
    .instr_retire_i(retire), .trap_i(trap), .trap_cause_i(trapCause),
    .trap_epc_i(trapEpc), .trap_tval_i(trapTval), .mret_i(mret),
    .timer_irq_i(timerIrq), .ext_irq_i(extIrq),
    .trap_pc_o(trapPc), .mret_pc_o(mretPc), .irq_pending_o(irqPend)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] maskOf(input int a);
    case (a)
      'h300:   return 64'h88;
      'h304:   return 64'h888;
      'h305:   return ~64'h2;
      'h341:   return ~64'h3;
      'h344:   return 64'h8;
      default: return ~64'h0;
    endcase
  endfunction

  function automatic void modelReset();
    int keys[$] = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344, 'hB00, 'hB02};
    st.delete();
    foreach (keys[i]) st[keys[i]] = 64'd0;
    expIrq = 1'b0;
  endfunction

  function automatic logic [63:0] modelRead(input int a);
    if (a == 'h301) return MISA;
    if (a == 'hF14) return 64'd0;
    if (a == 'h300) return st[a] | 64'h1800;
    if (a == 'h344) return st[a] | (64'(timerIrq) << 7) | (64'(extIrq) << 11);
    if (st.exists(a)) return st[a];
    return 64'd0;
  endfunction

  function automatic logic [63:0] modelTrapPc();
    logic [63:0] base = st['h305] & ~64'h3;
    if (st['h305][0] && trapCause[63]) return base + 64'(trapCause[5:0]) * 4;
    return base;
  endfunction

  function automatic void modelEdge();
    logic oldMie  = st['h300][3];
    logic oldMpie = st['h300][7];
    int   a = int'(csrAddr);
    expIrq = oldMie && ((st['h304] & modelRead('h344) & 64'h888) != 0);
    st['hB00] = st['hB00] + 1;
    st['hB02] = st['hB02] + 64'(retire);
    if (csrWe && st.exists(a)) st[a] = csrWdata & maskOf(a);
    if (trap) begin
      st['h341] = trapEpc & ~64'h3;
      st['h342] = trapCause;
      st['h343] = trapTval;
      st['h300] = oldMie ? 64'h80 : 64'h0;
    end else if (mret) begin
      st['h300] = (oldMpie ? 64'h8 : 64'h0) | 64'h80;
    end
  endfunction

  task automatic applyStimulus(input logic we, input logic [11:0] a, input logic [63:0] d,
                               input logic ret, input logic tr, input logic [63:0] cause,
                               input logic [63:0] epc, input logic [63:0] tval, input logic mr);
    csrWe = we; csrAddr = a; csrWdata = d; retire = ret;
    trap = tr; trapCause = cause; trapEpc = epc; trapTval = tval; mret = mr;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic writeCsr(input logic [11:0] a, input logic [63:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
    tick();
    applyStimulus(1'b0, a, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic checkRead(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csrWe = 1'b0;
    csrAddr = a;
    #1;
    checkOutput(tag, csrRdata, exp);
  endtask

  logic [11:0] addrPool [14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'h123};

  initial begin
    modelReset();
    // Reset state while rst_n is low
    #3;
    csrAddr = 12'h300;
    #1;
    checkOutput("rst_mstatus", csrRdata, 64'h1800);
    checkOutput("rst_trap_pc", trapPc, 64'd0);
    checkOutput("rst_mret_pc", mretPc, 64'd0);
    checkOutput("rst_irq", 64'(irqPend), 64'd0);
    csrAddr = 12'hB00;
    #1;
    checkOutput("rst_mcycle", csrRdata, 64'd0);
    #7;
    rstN = 1'b1;

    // Counters: 10 cycles, retire asserted for 3 of them
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 12'hB00, 64'd0, i < 3, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
      tick();
    end
    retire = 1'b0;
    checkRead("mcycle_10", 12'hB00, 64'd10);
    checkRead("minstret_3", 12'hB02, 64'd3);
    writeCsr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    checkRead("mcycle_loaded", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    checkRead("mcycle_wrap", 12'hB00, 64'd0);

    // Write is not bypassed to the read port in its own cycle
    applyStimulus(1'b1, 12'h340, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
    #1;
    checkOutput("mscratch_no_bypass", csrRdata, 64'd0);
    tick();
    checkRead("mscratch", 12'h340, 64'hDEAD_BEEF_0123_4567);
    writeCsr(12'h301, 64'd0);
    checkRead("misa_ro", 12'h301, MISA);
    writeCsr(12'h7C0, 64'h1234);
    checkRead("unimpl", 12'h7C0, 64'd0);
    checkRead("mhartid", 12'hF14, 64'd0);

    // WARL masks
    writeCsr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    checkRead("mstatus_warl", 12'h300, 64'h1888);
    writeCsr(12'h305, 64'h8000_0003);
    checkRead("mtvec_warl", 12'h305, 64'h8000_0001);
    writeCsr(12'h341, 64'h8000_0107);
    checkRead("mepc_warl", 12'h341, 64'h8000_0104);
    writeCsr(12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
    checkRead("mie_warl", 12'h304, 64'h888);
    writeCsr(12'h304, 64'd0);

    // Vectored trap entry and mret
    writeCsr(12'h305, 64'h1001);
    writeCsr(12'h300, 64'h8);
    applyStimulus(1'b0, 12'h341, 64'd0, 1'b0, 1'b1, 64'h8000_0000_0000_0007, 64'h2000, 64'h77, 1'b0);
    #1;
    checkOutput("trap_pc_vec", trapPc, 64'h101C);
    trapCause = 64'h5;
    #1;
    checkOutput("trap_pc_exc", trapPc, 64'h1000);
    trapCause = 64'h8000_0000_0000_0007;
    tick();
    applyStimulus(1'b0, 12'h341, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
    checkRead("trap_mepc", 12'h341, 64'h2000);
    checkRead("trap_mstatus", 12'h300, 64'h1880);
    checkRead("trap_mcause", 12'h342, 64'h8000_0000_0000_0007);
    checkOutput("mret_pc", mretPc, 64'h2000);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    checkRead("mret_mstatus", 12'h300, 64'h1888);

    // Trap, mret and a mepc write in one cycle
    applyStimulus(1'b1, 12'h341, 64'h3000, 1'b0, 1'b1, 64'h2, 64'h2000, 64'h55, 1'b1);
    tick();
    applyStimulus(1'b0, 12'h341, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
    checkRead("prio_mepc", 12'h341, 64'h2000);
    checkRead("prio_mstatus", 12'h300, 64'h1880);
    checkRead("prio_mtval", 12'h343, 64'h55);

    // Randomized phase against the model
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, addrPool[$urandom_range(0, 13)],
                    {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, $urandom_range(0, 5) == 0);
      timerIrq = $urandom_range(0, 1) == 1;
      extIrq   = $urandom_range(0, 1) == 1;
      #1;
      checkOutput("rnd_rdata", csrRdata, modelRead(int'(csrAddr)));
      checkOutput("rnd_trap_pc", trapPc, modelTrapPc());
      checkOutput("rnd_mret_pc", mretPc, st['h341]);
      checkOutput("rnd_irq", 64'(irqPend), 64'(expIrq));
      tick();
    end
    timerIrq = 1'b0;
    extIrq   = 1'b0;
    applyStimulus(1'b0, 12'h0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
    tick();

    // Timer interrupt latency, then asynchronous reset mid-run
    writeCsr(12'h304, 64'h80);
    writeCsr(12'h300, 64'h8);
    timerIrq = 1'b1;
    #1;
    checkOutput("irq_before_edge", 64'(irqPend), 64'd0);
    tick();
    checkOutput("irq_after_edge", 64'(irqPend), 64'd1);
    checkRead("mcycle_nonzero", 12'hB00, modelRead('hB00));
    #1;
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_irq", 64'(irqPend), 64'd0);
    checkOutput("async_rst_mcycle", csrRdata, 64'd0);
    timerIrq = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
Machine-mode CSR register file for the pipeline. It is the responder at the other end of the EX-stage CSR read/modify/write interface.
- Returns the current CSR value combinationally for the address presented by EX.
- Commits the EX-computed write value on the clock edge.
- Owns the mcycle/minstret counters, trap entry/return state and the timer/external interrupt pending logic.

Parameters:
HART_ID, 0, value returned by mhartid (0xF14)
MISA_VAL, 64'h8000_0000_0000_0100, read-only misa value (RV64I)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
csr_we_i  input  1  CSR write strobe from EX
csr_addr_i  input  12  CSR address from EX (read and write)
csr_data_i  input  64  write value from EX
csr_data_o  output  64  combinational read data for csr_addr_i
instr_retire_i  input  1  one instruction retired this cycle
trap_i  input  1  synchronous exception or interrupt taken this cycle
trap_cause_i  input  64  mcause value; bit 63 = interrupt
trap_epc_i  input  64  PC to save in mepc
trap_tval_i  input  64  value to save in mtval
mret_i  input  1  mret executed this cycle
timer_irq_i  input  1  level machine timer interrupt
ext_irq_i  input  1  level machine external interrupt
trap_pc_o  output  64  redirect target for the trap (combinational)
mret_pc_o  output  64  current mepc (combinational)
irq_pending_o  output  1  an enabled interrupt is pending and globally enabled

Behaviour:
Implemented CSRs:
- mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
- misa 0x301: read-only, returns MISA_VAL.
- mie 0x304: only MSIE[3], MTIE[7] and MEIE[11] are writable.
- mtvec 0x305: bit 1 reads 0; mode is bit 0 (0 = direct, 1 = vectored).
- mscratch 0x340: full 64-bit read/write.
- mepc 0x341: bits [1:0] read 0.
- mcause 0x342, mtval 0x343: full 64-bit read/write.
- mip 0x344: MSIP[3] is writable; MTIP[7] = timer_irq_i and MEIP[11] = ext_irq_i live (not writable).
- mcycle 0xB00, minstret 0xB02: 64-bit counters.
- mhartid 0xF14: read-only, returns HART_ID.

Read path:
- Purely combinational, zero latency: csr_data_o = value of csr_addr_i in the current cycle.
- Unimplemented addresses read 64'b0.
- No write bypass: a write is visible on the read port the cycle after the edge.

Write path:
- Takes effect at the rising edge with csr_we_i = 1.
- Writes to read-only or unimplemented addresses are silently ignored (csrrs/csrrc with rs1 = x0 also strobe csr_we_i).
- WARL masks above are applied on write.

Counters:
- mcycle increments by 1 every cycle.
- minstret increments when instr_retire_i = 1.
- Both wrap from 2^64-1 to 0.
- A CSR write to a counter in the same cycle wins over its increment: the written value is loaded, with no +1.

Trap entry (trap_i = 1):
- mepc <= trap_epc_i with [1:0] cleared.
- mcause <= trap_cause_i; mtval <= trap_tval_i.
- MPIE <= MIE; MIE <= 0.

trap_pc_o:
- Direct mode, or any exception: {mtvec[63:2], 2'b00}.
- Vectored mode with cause bit 63 = 1: {mtvec[63:2], 2'b00} + 4 × cause[5:0].

mret (mret_i = 1):
- MIE <= MPIE; MPIE <= 1.
- mret_pc_o always presents {mepc[63:2], 2'b00}.

Same-cycle priority for mstatus/mepc/mcause/mtval: trap_i > mret_i > CSR write.
- A CSR write to any other register in the same cycle still commits.
- trap_i and mret_i together: trap wins; mret is ignored.

irq_pending_o = mstatus.MIE & |(mie[11,7,3] & mip[11,7,3]). Registered: it reflects state and irq levels sampled at the previous edge, giving 1 cycle of latency from timer_irq_i/ext_irq_i rising.

Reset (asynchronous, rst_n low), effective immediately, mid-operation included:
- All writable CSRs are cleared: mstatus MIE/MPIE = 0, mie = 0, mtvec = 0, mscratch = 0, mepc = 0, mcause = 0, mtval = 0, MSIP = 0.
- mcycle = 0, minstret = 0; irq_pending_o = 0.
- Outputs read accordingly: csr_data_o for mstatus = 64'h1800, trap_pc_o = 0, mret_pc_o = 0.
- Counters start incrementing on the first edge after rst_n deasserts.

Test Plan:
1. Write mscratch 64'hDEAD_BEEF_0123_4567, then read 0x340 -> returns the value the cycle after the write edge, not the write cycle itself. Write misa 0 -> read still 64'h8000_0000_0000_0100. Read address 0x7C0 -> 0.
2. Write mstatus 64'hFFFF_FFFF_FFFF_FFFF -> reads 64'h1888. Write mtvec 64'h8000_0003 -> reads 64'h8000_0001. Write mepc 64'h8000_0107 -> reads 64'h8000_0104.
3. Release reset, hold instr_retire_i high for 3 of 10 cycles -> mcycle = 10, minstret = 3. Write mcycle 64'hFFFF_FFFF_FFFF_FFFF -> next cycle reads 0 (wrap).
4. Set mtvec = 64'h1001 and MIE = 1. Pulse trap_i with cause 64'h8000_0000_0000_0007, epc 64'h2000 -> trap_pc_o = 64'h101C; then mepc = 64'h2000, MIE = 0, MPIE = 1. Pulse mret_i -> MIE = 1, MPIE = 1, mret_pc_o = 64'h2000.
5. Assert trap_i, mret_i and a CSR write to mepc (64'h3000) in one cycle with trap_epc_i = 64'h2000 -> mepc = trap_epc_i (64'h2000), mret ignored.
6. Set MIE = 1, MTIE = 1, raise timer_irq_i -> irq_pending_o = 1 one cycle later. Assert rst_n low mid-run -> irq_pending_o = 0 and mcycle = 0 immediately, before any clock edge.
